// File: rtl/dispatch_stage.sv
// Dispatch stage: one-entry output register feeding ROB allocate and issue queue,
// plus the physical-register busy table with writeback wakeup/bypass.
module dispatch_stage #(
  parameter  int unsigned N_PHYS    = 64,
  parameter  int unsigned ROB_TAG_W = 6,
  parameter  int unsigned PAYLOAD_W = 32,
  localparam int unsigned PW        = $clog2(N_PHYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ren_valid_i,
  output logic                 ren_ready_o,
  input  logic [PW-1:0]        ren_rs1_p_i,
  input  logic [PW-1:0]        ren_rs2_p_i,
  input  logic [PW-1:0]        ren_rd_new_p_i,
  input  logic [PW-1:0]        ren_rd_old_p_i,
  input  logic                 ren_rd_alloc_i,
  input  logic [ROB_TAG_W-1:0] ren_rob_tag_i,
  input  logic [PAYLOAD_W-1:0] ren_payload_i,
  output logic                 rob_valid_o,
  input  logic                 rob_ready_i,
  output logic [ROB_TAG_W-1:0] rob_tag_o,
  output logic [PW-1:0]        rob_rd_new_p_o,
  output logic [PW-1:0]        rob_rd_old_p_o,
  output logic                 rob_rd_alloc_o,
  output logic                 iq_valid_o,
  input  logic                 iq_ready_i,
  output logic [PW-1:0]        iq_rs1_p_o,
  output logic [PW-1:0]        iq_rs2_p_o,
  output logic [PW-1:0]        iq_rd_p_o,
  output logic                 iq_rs1_rdy_o,
  output logic                 iq_rs2_rdy_o,
  output logic [ROB_TAG_W-1:0] iq_rob_tag_o,
  output logic [PAYLOAD_W-1:0] iq_payload_o,
  input  logic                 wb_valid_i,
  input  logic [PW-1:0]        wb_preg_i,
  input  logic                 recover_i
);

  logic                 out_valid_q, out_valid_d;
  logic [PW-1:0]        rs1_p_q, rs1_p_d, rs2_p_q, rs2_p_d;
  logic [PW-1:0]        rd_new_p_q, rd_new_p_d, rd_old_p_q, rd_old_p_d;
  logic                 rd_alloc_q, rd_alloc_d;
  logic                 rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [ROB_TAG_W-1:0] tag_q, tag_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [N_PHYS-1:0]    busy_q, busy_d;

  logic fire, accept;
  logic held_rs1_wb, held_rs2_wb, new_rs1_wb, new_rs2_wb;

  always_comb begin
    // Recovery suppresses both valids, so it also suppresses fire.
    fire        = out_valid_q & rob_ready_i & iq_ready_i & ~recover_i;
    ren_ready_o = (~out_valid_q | fire) & ~recover_i;
    accept      = ren_valid_i & ren_ready_o;
    held_rs1_wb = wb_valid_i & (wb_preg_i == rs1_p_q);
    held_rs2_wb = wb_valid_i & (wb_preg_i == rs2_p_q);
    new_rs1_wb  = wb_valid_i & (wb_preg_i == ren_rs1_p_i);
    new_rs2_wb  = wb_valid_i & (wb_preg_i == ren_rs2_p_i);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rs1_p_d     = rs1_p_q;
    rs2_p_d     = rs2_p_q;
    rd_new_p_d  = rd_new_p_q;
    rd_old_p_d  = rd_old_p_q;
    rd_alloc_d  = rd_alloc_q;
    rs1_rdy_d   = rs1_rdy_q;
    rs2_rdy_d   = rs2_rdy_q;
    tag_d       = tag_q;
    payload_d   = payload_q;
    if (recover_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      rs1_p_d     = ren_rs1_p_i;
      rs2_p_d     = ren_rs2_p_i;
      rd_new_p_d  = ren_rd_new_p_i;
      rd_old_p_d  = ren_rd_old_p_i;
      rd_alloc_d  = ren_rd_alloc_i;
      tag_d       = ren_rob_tag_i;
      payload_d   = ren_payload_i;
      rs1_rdy_d   = ~busy_q[ren_rs1_p_i] | new_rs1_wb;
      rs2_rdy_d   = ~busy_q[ren_rs2_p_i] | new_rs2_wb;
    end else if (fire) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      rs1_rdy_d = rs1_rdy_q | held_rs1_wb;
      rs2_rdy_d = rs2_rdy_q | held_rs2_wb;
    end
  end

  // Clear first so a same-cycle set of the same preg wins; p0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i)
      busy_d[wb_preg_i] = 1'b0;
    if (accept && ren_rd_alloc_i && (ren_rd_new_p_i != '0))
      busy_d[ren_rd_new_p_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rs1_p_q     <= '0;
      rs2_p_q     <= '0;
      rd_new_p_q  <= '0;
      rd_old_p_q  <= '0;
      rd_alloc_q  <= 1'b0;
      rs1_rdy_q   <= 1'b1;
      rs2_rdy_q   <= 1'b1;
      tag_q       <= '0;
      payload_q   <= '0;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_p_q     <= rs1_p_d;
      rs2_p_q     <= rs2_p_d;
      rd_new_p_q  <= rd_new_p_d;
      rd_old_p_q  <= rd_old_p_d;
      rd_alloc_q  <= rd_alloc_d;
      rs1_rdy_q   <= rs1_rdy_d;
      rs2_rdy_q   <= rs2_rdy_d;
      tag_q       <= tag_d;
      payload_q   <= payload_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    rob_valid_o    = out_valid_q & ~recover_i;
    iq_valid_o     = out_valid_q & ~recover_i;
    rob_tag_o      = tag_q;
    rob_rd_new_p_o = rd_new_p_q;
    rob_rd_old_p_o = rd_old_p_q;
    rob_rd_alloc_o = rd_alloc_q;
    iq_rs1_p_o     = rs1_p_q;
    iq_rs2_p_o     = rs2_p_q;
    iq_rd_p_o      = rd_new_p_q;
    iq_rs1_rdy_o   = rs1_rdy_q | held_rs1_wb;
    iq_rs2_rdy_o   = rs2_rdy_q | held_rs2_wb;
    iq_rob_tag_o   = tag_q;
    iq_payload_o   = payload_q;
  end

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed self-checking bench for dispatch_stage.
module tb_dispatch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren_valid_i, ren_ready_o, ren_rd_alloc_i;
  logic [5:0]  ren_rs1_p_i, ren_rs2_p_i, ren_rd_new_p_i, ren_rd_old_p_i, ren_rob_tag_i;
  logic [31:0] ren_payload_i;
  logic        rob_valid_o, rob_ready_i, rob_rd_alloc_o;
  logic [5:0]  rob_tag_o, rob_rd_new_p_o, rob_rd_old_p_o;
  logic        iq_valid_o, iq_ready_i, iq_rs1_rdy_o, iq_rs2_rdy_o;
  logic [5:0]  iq_rs1_p_o, iq_rs2_p_o, iq_rd_p_o, iq_rob_tag_o;
  logic [31:0] iq_payload_o;
  logic        wb_valid_i, recover_i;
  logic [5:0]  wb_preg_i;

  int checks = 0;
  int errors = 0;

  dispatch_stage #(.N_PHYS(64), .ROB_TAG_W(6), .PAYLOAD_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ren_valid_i(ren_valid_i), .ren_ready_o(ren_ready_o),
    .ren_rs1_p_i(ren_rs1_p_i), .ren_rs2_p_i(ren_rs2_p_i),
    .ren_rd_new_p_i(ren_rd_new_p_i), .ren_rd_old_p_i(ren_rd_old_p_i),
    .ren_rd_alloc_i(ren_rd_alloc_i), .ren_rob_tag_i(ren_rob_tag_i),
    .ren_payload_i(ren_payload_i),
    .rob_valid_o(rob_valid_o), .rob_ready_i(rob_ready_i), .rob_tag_o(rob_tag_o),
    .rob_rd_new_p_o(rob_rd_new_p_o), .rob_rd_old_p_o(rob_rd_old_p_o),
    .rob_rd_alloc_o(rob_rd_alloc_o),
    .iq_valid_o(iq_valid_o), .iq_ready_i(iq_ready_i),
    .iq_rs1_p_o(iq_rs1_p_o), .iq_rs2_p_o(iq_rs2_p_o), .iq_rd_p_o(iq_rd_p_o),
    .iq_rs1_rdy_o(iq_rs1_rdy_o), .iq_rs2_rdy_o(iq_rs2_rdy_o),
    .iq_rob_tag_o(iq_rob_tag_o), .iq_payload_o(iq_payload_o),
    .wb_valid_i(wb_valid_i), .wb_preg_i(wb_preg_i), .recover_i(recover_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rdn,
                       input logic alloc, input logic [5:0] tag);
    ren_valid_i    = 1'b1;
    ren_rs1_p_i    = rs1;
    ren_rs2_p_i    = rs2;
    ren_rd_new_p_i = rdn;
    ren_rd_old_p_i = rdn ^ 6'h3f;
    ren_rd_alloc_i = alloc;
    ren_rob_tag_i  = tag;
    ren_payload_i  = {26'h2ab_cdef, tag};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ren_valid_i = 1'b0; ren_rs1_p_i = '0; ren_rs2_p_i = '0;
    ren_rd_new_p_i = '0; ren_rd_old_p_i = '0; ren_rd_alloc_i = 1'b0;
    ren_rob_tag_i = '0; ren_payload_i = '0; rob_ready_i = 1'b1; iq_ready_i = 1'b1;
    wb_valid_i = 1'b0; wb_preg_i = '0; recover_i = 1'b0;
    #12;
    checks++;
    if ({ren_ready_o, rob_valid_o, iq_valid_o, iq_rs1_rdy_o, iq_rs2_rdy_o} !== 5'b10011) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10011",
               {ren_ready_o, rob_valid_o, iq_valid_o, iq_rs1_rdy_o, iq_rs2_rdy_o});
    end
    checks++;
    if ({rob_tag_o, iq_rd_p_o, iq_payload_o} !== 44'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 0", {rob_tag_o, iq_rd_p_o, iq_payload_o});
    end
    tick();
    rst_n = 1'b1;
    drive(6'd5, 6'd0, 6'd33, 1'b1, 6'd0);
    tick();
    checks++;
    if ({rob_valid_o, iq_valid_o, iq_rs1_rdy_o, iq_rs2_rdy_o, iq_rd_p_o} !== {4'b1111, 6'd33}) begin
      errors++;
      $display("FAIL first_dispatch: got %b/%0d want 1111/33",
               {rob_valid_o, iq_valid_o, iq_rs1_rdy_o, iq_rs2_rdy_o}, iq_rd_p_o);
    end
  endtask

  task automatic test_dependency();
    drive(6'd33, 6'd0, 6'd34, 1'b1, 6'd1);
    tick();
    ren_valid_i = 1'b0;
    iq_ready_i  = 1'b0;
    checks++;
    if ({iq_rob_tag_o, iq_rs1_rdy_o, iq_rs2_rdy_o} !== {6'd1, 2'b01}) begin
      errors++;
      $display("FAIL dep_capture: got tag %0d rdy %b want tag 1 rdy 01",
               iq_rob_tag_o, {iq_rs1_rdy_o, iq_rs2_rdy_o});
    end
    wb_valid_i = 1'b1; wb_preg_i = 6'd33;
    #1;
    checks++;
    if ({iq_rs1_rdy_o, ren_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL dep_bypass: got rdy/ren_ready %b want 10", {iq_rs1_rdy_o, ren_ready_o});
    end
    tick();
    wb_valid_i = 1'b0;
    #1;
    checks++;
    if ({iq_valid_o, iq_rs1_rdy_o, iq_rob_tag_o} !== {2'b11, 6'd1}) begin
      errors++;
      $display("FAIL dep_hold: got %b tag %0d want 11 tag 1",
               {iq_valid_o, iq_rs1_rdy_o}, iq_rob_tag_o);
    end
  endtask

  task automatic test_backpressure();
    rob_ready_i = 1'b0; iq_ready_i = 1'b1;
    drive(6'd34, 6'd0, 6'd0, 1'b0, 6'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ren_ready_o, rob_valid_o, rob_tag_o, iq_rd_p_o} !== {2'b01, 6'd1, 6'd34}) begin
        errors++;
        $display("FAIL bp_stall%0d: got ready %b valid %b tag %0d rd %0d want 0 1 1 34",
                 i, ren_ready_o, rob_valid_o, rob_tag_o, iq_rd_p_o);
      end
      tick();
    end
    rob_ready_i = 1'b1;
    #1;
    checks++;
    if (ren_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ren_ready got %b want 1", ren_ready_o);
    end
    tick();
    ren_valid_i = 1'b0;
    checks++;
    if ({rob_valid_o, rob_tag_o, iq_rs1_rdy_o} !== {1'b1, 6'd2, 1'b0}) begin
      errors++;
      $display("FAIL bp_next: got valid %b tag %0d rdy %b want 1 2 0",
               rob_valid_o, rob_tag_o, iq_rs1_rdy_o);
    end
    tick();
    checks++;
    if ({rob_valid_o, iq_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL bp_single_fire: valids got %b want 00", {rob_valid_o, iq_valid_o});
    end
    wb_valid_i = 1'b1; wb_preg_i = 6'd34;
    tick();
    wb_valid_i = 1'b0;
  endtask

  task automatic test_same_cycle();
    drive(6'd0, 6'd0, 6'd40, 1'b1, 6'd3);
    wb_valid_i = 1'b1; wb_preg_i = 6'd40;
    tick();
    wb_valid_i = 1'b0;
    drive(6'd40, 6'd0, 6'd0, 1'b1, 6'd4);
    tick();
    checks++;
    if (iq_rs1_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL set_wins: rs1_rdy for p40 got %b want 0", iq_rs1_rdy_o);
    end
    drive(6'd0, 6'd0, 6'd0, 1'b0, 6'd5);
    tick();
    checks++;
    if ({iq_rs1_rdy_o, iq_rs2_rdy_o} !== 2'b11) begin
      errors++;
      $display("FAIL p0_never_busy: got %b want 11", {iq_rs1_rdy_o, iq_rs2_rdy_o});
    end
    ren_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_preg_i = 6'd40;
    tick();
    wb_valid_i = 1'b0;
    drive(6'd40, 6'd0, 6'd0, 1'b0, 6'd6);
    tick();
    ren_valid_i = 1'b0;
    checks++;
    if (iq_rs1_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL wb_clear: rs1_rdy for p40 got %b want 1", iq_rs1_rdy_o);
    end
    tick();
  endtask

  task automatic test_recovery();
    iq_ready_i = 1'b0;
    drive(6'd0, 6'd0, 6'd50, 1'b1, 6'd10);
    tick();
    drive(6'd0, 6'd0, 6'd51, 1'b1, 6'd11);
    recover_i = 1'b1;
    #1;
    checks++;
    if ({rob_valid_o, iq_valid_o, ren_ready_o} !== 3'b000) begin
      errors++;
      $display("FAIL recover_now: got %b want 000", {rob_valid_o, iq_valid_o, ren_ready_o});
    end
    tick();
    recover_i = 1'b0; ren_valid_i = 1'b0; iq_ready_i = 1'b1;
    #1;
    checks++;
    if ({rob_valid_o, iq_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL recover_after: valids got %b want 00", {rob_valid_o, iq_valid_o});
    end
    drive(6'd50, 6'd51, 6'd0, 1'b0, 6'd12);
    tick();
    ren_valid_i = 1'b0;
    checks++;
    if ({iq_rob_tag_o, iq_rs1_rdy_o, iq_rs2_rdy_o} !== {6'd12, 2'b01}) begin
      errors++;
      $display("FAIL recover_busy: got tag %0d rdy %b want tag 12 rdy 01",
               iq_rob_tag_o, {iq_rs1_rdy_o, iq_rs2_rdy_o});
    end
    wb_valid_i = 1'b1; wb_preg_i = 6'd50;
    tick();
    wb_valid_i = 1'b0;
  endtask

  task automatic test_streaming();
    logic [5:0] rd_prev, rd_cur;
    rd_prev = 6'd0;
    rd_cur  = 6'd1;
    drive(6'd0, 6'd0, rd_cur, 1'b1, 6'd0);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (ren_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready%0d: got %b want 1", i, ren_ready_o);
      end
      tick();
      checks++;
      if ({iq_valid_o, iq_rob_tag_o, iq_payload_o, iq_rs1_rdy_o} !==
          {1'b1, 6'(i), {26'h2ab_cdef, 6'(i)}, (i == 0) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL stream%0d: got valid %b tag %0d pay %h rdy %b", i,
                 iq_valid_o, iq_rob_tag_o, iq_payload_o, iq_rs1_rdy_o);
      end
      rd_prev = rd_cur;
      rd_cur  = 6'((i + 1) % 63 + 1);
      if (i < 63) drive(rd_prev, 6'd0, rd_cur, 1'b1, 6'(i + 1));
      else ren_valid_i = 1'b0;
    end
    tick();
    drive(6'd20, 6'd0, 6'd0, 1'b0, 6'd0);
    tick();
    ren_valid_i = 1'b0;
    checks++;
    if ({iq_rob_tag_o, iq_rs1_rdy_o} !== {6'd0, 1'b0}) begin
      errors++;
      $display("FAIL stream_busy20: got tag %0d rdy %b want tag 0 rdy 0", iq_rob_tag_o, iq_rs1_rdy_o);
    end
    wb_valid_i = 1'b1; wb_preg_i = 6'd20;
    tick();
    wb_valid_i = 1'b0;
    drive(6'd20, 6'd0, 6'd0, 1'b0, 6'd1);
    tick();
    checks++;
    if (iq_rs1_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL stream_free20: rdy got %b want 1", iq_rs1_rdy_o);
    end
    drive(6'd21, 6'd22, 6'd0, 1'b0, 6'd2);
    wb_valid_i = 1'b1; wb_preg_i = 6'd21;
    tick();
    wb_valid_i = 1'b0; ren_valid_i = 1'b0;
    checks++;
    if ({iq_rs1_rdy_o, iq_rs2_rdy_o} !== 2'b10) begin
      errors++;
      $display("FAIL capture_bypass: got %b want 10", {iq_rs1_rdy_o, iq_rs2_rdy_o});
    end
    tick();
  endtask

  task automatic test_reset_midstall();
    iq_ready_i = 1'b0;
    drive(6'd0, 6'd0, 6'd0, 1'b0, 6'd7);
    tick();
    ren_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rob_valid_o, iq_valid_o, ren_ready_o, rob_tag_o} !== {3'b001, 6'd0}) begin
      errors++;
      $display("FAIL reset_midstall: got %b tag %0d want 001 tag 0",
               {rob_valid_o, iq_valid_o, ren_ready_o}, rob_tag_o);
    end
  endtask

  initial begin
    test_reset();
    test_dependency();
    test_backpressure();
    test_same_cycle();
    test_recovery();
    test_streaming();
    test_reset_midstall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
